// File: rtl/root_hub_link_if.sv
// Bundle of the root hub link handshake buses: controller downstream and upstream ports
// plus the per-child transmit and receive links.
interface root_hub_link_if #(
   parameter int NUM_CHILDREN   = 4,
   parameter int DROP_CNT_WIDTH = 16
);
   logic [63:0]                 down_in_data;
   logic                        down_in_valid;
   logic                        down_in_ready;
   logic [64*NUM_CHILDREN-1:0]  child_tx_data;
   logic [NUM_CHILDREN-1:0]     child_tx_valid;
   logic [NUM_CHILDREN-1:0]     child_tx_ready;
   logic [64*NUM_CHILDREN-1:0]  child_rx_data;
   logic [NUM_CHILDREN-1:0]     child_rx_valid;
   logic [NUM_CHILDREN-1:0]     child_rx_ready;
   logic [63:0]                 up_out_data;
   logic                        up_out_valid;
   logic                        up_out_ready;
   logic [DROP_CNT_WIDTH-1:0]   drop_count;
   logic                        busy;

   modport master (
      output down_in_data, down_in_valid, child_tx_ready,
             child_rx_data, child_rx_valid, up_out_ready,
      input  down_in_ready, child_tx_data, child_tx_valid, child_rx_ready,
             up_out_data, up_out_valid, drop_count, busy
   );

   modport slave (
      input  down_in_data, down_in_valid, child_tx_ready,
             child_rx_data, child_rx_valid, up_out_ready,
      output down_in_ready, child_tx_data, child_tx_valid, child_rx_ready,
             up_out_data, up_out_valid, drop_count, busy
   );
endinterface

// File: rtl/root_hub_link.sv
// Root-side hub: routes controller messages to leaf links by destination ID (or broadcast)
// and merges leaf messages round-robin into one upstream stream stamped with the source ID.
module root_hub_link #(
   parameter int         NUM_CHILDREN   = 4,
   parameter logic [7:0] BROADCAST_ID   = 8'hFF,
   parameter int         DROP_CNT_WIDTH = 16
) (
   input  logic           clk,
   input  logic           reset,
   root_hub_link_if.slave bus
);
   localparam int         PTR_W  = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
   localparam logic [7:0] MAX_ID = 8'(NUM_CHILDREN);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                    state_reg;
   logic [63:0]               tx_data_reg [NUM_CHILDREN];
   logic [NUM_CHILDREN-1:0]   tx_valid_reg;
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;
   logic [63:0]               up_data_reg;
   logic                      up_valid_reg;
   logic [PTR_W-1:0]          ptr_reg;

   logic [63:0]               rx_data [NUM_CHILDREN];
   logic [7:0]                dest;
   logic                      dest_bcast;
   logic                      dest_unicast;
   logic [NUM_CHILDREN-1:0]   dest_mask;
   logic [NUM_CHILDREN-1:0]   tx_valid_next;
   logic                      up_free;
   logic                      grant_found;
   logic [PTR_W-1:0]          grant_idx;
   logic [PTR_W:0]            cand;

   assign dest          = bus.down_in_data[55:48];
   assign dest_bcast    = (dest == BROADCAST_ID);
   assign dest_unicast  = (dest != 8'd0) && (dest <= MAX_ID);
   assign tx_valid_next = tx_valid_reg & ~bus.child_tx_ready;
   assign up_free       = !up_valid_reg || bus.up_out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHILDREN; gi++) begin : g_child
         assign dest_mask[gi]                 = dest_bcast || (dest_unicast && dest == 8'(gi + 1));
         assign bus.child_tx_data[gi*64 +: 64] = tx_data_reg[gi];
         assign rx_data[gi]                    = bus.child_rx_data[gi*64 +: 64];
         assign bus.child_rx_ready[gi]         = up_free && grant_found && (grant_idx == PTR_W'(gi));
      end
   endgenerate

   // Downstream FSM: a message stays in SEND until every addressed child has taken it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         tx_valid_reg <= '0;
         drop_cnt_reg <= '0;
         for (int k = 0; k < NUM_CHILDREN; k++) tx_data_reg[k] <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.down_in_valid) begin
                  if (|dest_mask) begin
                     for (int k = 0; k < NUM_CHILDREN; k++)
                        if (dest_mask[k]) tx_data_reg[k] <= bus.down_in_data;
                     tx_valid_reg <= dest_mask;
                     state_reg    <= SEND;
                  end else if (drop_cnt_reg != '1) begin
                     drop_cnt_reg <= drop_cnt_reg + DROP_CNT_WIDTH'(1);
                  end
               end
            end
            SEND: begin
               tx_valid_reg <= tx_valid_next;
               if (tx_valid_next == '0) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // First valid child at or after the pointer, scanning cyclically.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NUM_CHILDREN)) cand = cand - (PTR_W+1)'(NUM_CHILDREN);
         if (!grant_found && bus.child_rx_valid[cand[PTR_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up_data_reg  <= '0;
         up_valid_reg <= 1'b0;
         ptr_reg      <= '0;
      end else if (up_free) begin
         if (grant_found) begin
            up_data_reg  <= {rx_data[grant_idx][63:56], 8'(grant_idx) + 8'd1, rx_data[grant_idx][47:0]};
            up_valid_reg <= 1'b1;
            ptr_reg      <= (grant_idx == PTR_W'(NUM_CHILDREN - 1)) ? '0 : grant_idx + PTR_W'(1);
         end else begin
            up_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.down_in_ready  = (state_reg == IDLE);
   assign bus.child_tx_valid = tx_valid_reg;
   assign bus.up_out_data    = up_data_reg;
   assign bus.up_out_valid   = up_valid_reg;
   assign bus.drop_count     = drop_cnt_reg;
   assign bus.busy           = (state_reg == SEND) || up_valid_reg || (|bus.child_rx_valid);
endmodule

// File: tb/tb_root_hub_link.sv
// Bench for root_hub_link: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_root_hub_link;
   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   root_hub_link_if #(.NUM_CHILDREN(N), .DROP_CNT_WIDTH(DW)) bus ();

   root_hub_link #(.NUM_CHILDREN(N), .BROADCAST_ID(8'hFF), .DROP_CNT_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [N-1:0]  m_pend;
   logic [63:0]   m_tx_data [N];
   logic [DW-1:0] m_drop;
   logic          m_up_valid;
   logic [63:0]   m_up_data;
   int            m_ptr;
   logic [N-1:0]  hs_mask;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick_grant(input logic [N-1:0] v, input int ptr);
      for (int d = 0; d < N; d++)
         if (v[(ptr + d) % N]) return (ptr + d) % N;
      return -1;
   endfunction

   function automatic logic [63:0] stamp(input logic [63:0] d, input int g);
      return {d[63:56], 8'(g + 1), d[47:0]};
   endfunction

   always @(posedge clk or negedge reset) begin
      int g;
      int d;
      if (!reset) begin
         m_pend <= '0; m_drop <= '0; m_up_valid <= 1'b0; m_up_data <= '0;
         m_ptr <= 0; hs_mask <= '0;
         for (int k = 0; k < N; k++) m_tx_data[k] <= '0;
      end else begin
         g = pick_grant(bus.child_rx_valid, m_ptr);
         hs_mask <= '0;
         if (!m_up_valid || bus.up_out_ready) begin
            if (g >= 0) begin
               m_up_valid <= 1'b1;
               m_up_data  <= stamp(bus.child_rx_data[g*64 +: 64], g);
               m_ptr      <= (g + 1) % N;
               hs_mask    <= N'(1) << g;
            end else begin
               m_up_valid <= 1'b0;
            end
         end
         if (m_pend == '0) begin
            if (bus.down_in_valid) begin
               d = int'(bus.down_in_data[55:48]);
               if (d == 255) begin
                  m_pend <= '1;
                  for (int k = 0; k < N; k++) m_tx_data[k] <= bus.down_in_data;
               end else if (d >= 1 && d <= N) begin
                  m_pend <= N'(1) << (d - 1);
                  m_tx_data[d-1] <= bus.down_in_data;
               end else if (m_drop != '1) begin
                  m_drop <= m_drop + DW'(1);
               end
            end
         end else begin
            m_pend <= m_pend & ~bus.child_tx_ready;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      int g;
      logic [N-1:0] er;
      g  = pick_grant(bus.child_rx_valid, m_ptr);
      er = '0;
      if ((!m_up_valid || bus.up_out_ready) && g >= 0) er[g] = 1'b1;
      chk("down_in_ready", bus.down_in_ready, (m_pend == '0));
      chk("child_tx_valid", bus.child_tx_valid, m_pend);
      for (int k = 0; k < N; k++)
         if (m_pend[k]) chk("child_tx_data", bus.child_tx_data[k*64 +: 64], m_tx_data[k]);
      chk("child_rx_ready", bus.child_rx_ready, er);
      chk("up_out_valid", bus.up_out_valid, m_up_valid);
      if (m_up_valid) chk("up_out_data", bus.up_out_data, m_up_data);
      chk("drop_count", bus.drop_count, m_drop);
      chk("busy", bus.busy, (m_pend != '0) || m_up_valid || (|bus.child_rx_valid));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] msg(input logic [7:0] dest, input logic [63:0] body);
      return {body[63:56], dest, body[47:0]};
   endfunction

   initial begin
      logic [63:0] d1, d2;
      int rdy [N];
      logic [N-1:0] ev;
      reset = 1'b0;
      bus.down_in_data = '0; bus.down_in_valid = 1'b0; bus.child_tx_ready = '0;
      bus.child_rx_data = '0; bus.child_rx_valid = '0; bus.up_out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_valid", bus.child_tx_valid, 4'b0000);
      chk("rst_tx_data", bus.child_tx_data[63:0], 64'h0);
      chk("rst_up_valid", bus.up_out_valid, 1'b0);
      chk("rst_drop", bus.drop_count, 8'h00);
      tick();
      reset = 1'b1;
      tick();

      // Unicast to ID 3
      bus.down_in_data = 64'h0003_1234_5678_ABCD; bus.down_in_valid = 1'b1; bus.child_tx_ready = 4'hF;
      @(negedge clk); chk("uni_ready_T", bus.down_in_ready, 1'b1);
      tick(); bus.down_in_valid = 1'b0;
      @(negedge clk);
      chk("uni_valid", bus.child_tx_valid, 4'b0100);
      chk("uni_data", bus.child_tx_data[2*64 +: 64], 64'h0003_1234_5678_ABCD);
      chk("uni_ready_T1", bus.down_in_ready, 1'b0);
      tick();
      @(negedge clk);
      chk("uni_ready_T2", bus.down_in_ready, 1'b1);
      chk("uni_valid_done", bus.child_tx_valid, 4'b0000);

      // Broadcast with staggered per-child ready; a unicast waits behind it
      rdy[0] = 1; rdy[1] = 3; rdy[2] = 5; rdy[3] = 2;
      tick();
      bus.child_tx_ready = '0;
      bus.down_in_data = 64'h77FF_0000_0000_0001; bus.down_in_valid = 1'b1;
      tick();
      bus.down_in_data = 64'h1101_0000_0000_0002;
      for (int c = 1; c <= 6; c++) begin
         for (int k = 0; k < N; k++) begin
            bus.child_tx_ready[k] = (rdy[k] == c);
            ev[k] = (rdy[k] >= c);
         end
         @(negedge clk);
         chk("bc_valid", bus.child_tx_valid, ev);
         chk("bc_ready", bus.down_in_ready, (c == 6));
         tick();
      end
      bus.down_in_valid = 1'b0; bus.child_tx_ready = 4'hF;
      @(negedge clk);
      chk("bc_next_valid", bus.child_tx_valid, 4'b0001);
      chk("bc_next_data", bus.child_tx_data[63:0], 64'h1101_0000_0000_0002);
      tick();

      // Invalid destinations
      bus.down_in_valid = 1'b1;
      foreach (rdy[i]) rdy[i] = 0;
      for (int i = 0; i < 3; i++) begin
         bus.down_in_data = msg((i == 0) ? 8'h00 : (i == 1) ? 8'h05 : 8'h10, 64'hDEAD_0000_BEEF_0000);
         @(negedge clk); chk("inv_ready", bus.down_in_ready, 1'b1);
         tick();
      end
      bus.down_in_valid = 1'b0;
      @(negedge clk);
      chk("inv_drop3", bus.drop_count, 8'd3);
      chk("inv_no_valid", bus.child_tx_valid, 4'b0000);

      // Saturation of the drop counter
      tick();
      bus.down_in_valid = 1'b1; bus.down_in_data = msg(8'h42, 64'h0);
      repeat (300) tick();
      bus.down_in_valid = 1'b0;
      @(negedge clk); chk("drop_sat", bus.drop_count, 8'hFF);

      // Reset in the middle of a broadcast
      tick();
      bus.child_tx_ready = '0; bus.down_in_valid = 1'b1; bus.down_in_data = msg(8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
      tick();
      bus.down_in_valid = 1'b0; bus.child_tx_ready = 4'b0011;
      tick();
      bus.child_tx_ready = '0;
      @(negedge clk); chk("mid_pending", bus.child_tx_valid, 4'b1100);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", bus.child_tx_valid, 4'b0000);
      chk("mid_rst_data", bus.child_tx_data[127:64], 64'h0);
      chk("mid_rst_drop", bus.drop_count, 8'h00);
      chk("mid_rst_up", bus.up_out_valid, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", bus.down_in_ready, 1'b1);
      chk("mid_rel_drop", bus.drop_count, 8'h00);
      tick();

      // Fairness: all children valid, controller always ready
      bus.up_out_ready = 1'b1;
      for (int k = 0; k < N; k++) bus.child_rx_data[k*64 +: 64] = {8'(8'hA0 + k), 8'h00, 48'(k)};
      bus.child_rx_valid = 4'hF;
      @(negedge clk); chk("fair_first_rdy", bus.child_rx_ready, 4'b0001);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fair_src_id", bus.up_out_data[55:48], 8'((i % 4) + 1));
         chk("fair_payload", bus.up_out_data[63:56], 8'(8'hA0 + (i % 4)));
         tick();
      end

      // Backpressure from the controller with child 2 valid
      bus.child_rx_valid = '0;
      tick(); tick();
      d1 = 64'hC1C2_C3C4_C5C6_C7C8; d2 = 64'hD1D2_D3D4_D5D6_D7D8;
      bus.up_out_ready = 1'b0; bus.child_rx_valid = 4'b0100; bus.child_rx_data[2*64 +: 64] = d1;
      @(negedge clk); chk("bp_grant", bus.child_rx_ready, 4'b0100);
      tick();
      bus.child_rx_data[2*64 +: 64] = d2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus.up_out_valid, 1'b1);
         chk("bp_hold_data", bus.up_out_data, 64'hC103_C3C4_C5C6_C7C8);
         chk("bp_no_rdy", bus.child_rx_ready, 4'b0000);
         tick();
      end
      bus.up_out_ready = 1'b1;
      @(negedge clk); chk("bp_release_rdy", bus.child_rx_ready, 4'b0100);
      tick();
      bus.child_rx_valid = '0;
      @(negedge clk); chk("bp_next_data", bus.up_out_data, 64'hD103_D3D4_D5D6_D7D8);
      tick();

      // Randomized concurrent traffic in both directions
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         r = int'($urandom_range(0, 7));
         bus.down_in_valid  = ($urandom_range(0, 2) != 0);
         bus.down_in_data   = msg((r < 4) ? 8'(r + 1) : (r == 4) ? 8'hFF : (r == 5) ? 8'h00 :
                                  (r == 6) ? 8'(5 + $urandom_range(0, 9)) : 8'($urandom),
                                  {$urandom, $urandom});
         bus.child_tx_ready = N'($urandom);
         bus.up_out_ready   = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++) begin
            if (!bus.child_rx_valid[k] || hs_mask[k]) begin
               bus.child_rx_valid[k]          = $urandom_range(0, 1) == 1;
               bus.child_rx_data[k*64 +: 64]  = {$urandom, $urandom};
            end
         end
         tick();
      end

      bus.down_in_valid = 1'b0; bus.child_rx_valid = '0; bus.up_out_ready = 1'b1; bus.child_tx_ready = 4'hF;
      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
